// File: rtl/shared_mem_pkg.sv
// Shared definitions for the shared data memory arbiter: FSM state encoding,
// default widths and a helper for sizing the hold counter.
package shared_mem_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_MAX_HOLD  = 8;

    // Arbiter ownership state: nobody, the host, or one core.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOST = 2'd1,
        CORE = 2'd2
    } arb_state_t;

    // Width of a counter that must reach max_hold-1 (at least one bit).
    function automatic int hold_width(input int max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr (wrapping at N) as a one-hot vector and as an index.
module rr_pick #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // ptr + off reduced modulo N; off never exceeds N-1.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                   input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) sum = sum - N;
        return IDX_W'(sum);
    endfunction

    // Scan the candidates in priority order starting at ptr; first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = wrap_add(ptr, i);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Arbiter for the single-port shared data memory. The host has absolute
// priority; cores share the remaining bandwidth round-robin with a bounded
// hold time. Every hand-over passes through IDLE, giving one bubble cycle.
//
// Handshake: req is a level held for as long as the requester wants the
// memory. Each cycle in which a requester sees its gnt high while its req is
// high is exactly one memory access; for a read, that requester's rvalid is
// high on the following cycle together with rdata, whether or not it still
// owns the memory then.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_req,
    input  logic                        host_we,
    input  logic [ADDR_W-1:0]           host_addr,
    input  logic [DATA_W-1:0]           host_wdata,
    output logic                        host_gnt,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        host_rvalid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output arb_state_t                  dbg_state
);

    localparam int IDX_W  = $clog2(NUM_CORES);
    localparam int HOLD_W = hold_width(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CORES - 1);

    arb_state_t               state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [NUM_CORES-1:0]     owner_oh_q, owner_oh_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]        hold_q, hold_d;

    logic [NUM_CORES-1:0]     pick_gnt;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;
    logic                     owner_req;
    logic                     others_req;

    rr_pick #(.N(NUM_CORES)) u_rr_pick (
        .req (core_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_req  = |(core_req & owner_oh_q);
    assign others_req = |(core_req & ~owner_oh_q);

    // State register: ownership, round-robin pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            rr_ptr_q   <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
        end
    end

    // Next-state logic: host first, then round-robin core pick, bounded hold.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d = HOST;
                end else if (pick_any) begin
                    state_d    = CORE;
                    owner_d    = pick_idx;
                    owner_oh_d = pick_gnt;
                    hold_d     = '0;
                end
            end
            HOST: begin
                if (!host_req) state_d = IDLE;
            end
            CORE: begin
                // Give up on: owner done, host preemption, or hold budget used
                // up while someone else waits. A lone requester keeps the grant.
                if (!owner_req || host_req || (hold_q == HOLD_LAST && others_req)) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                    hold_d   = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: grants decoded from registered state, memory mux from the owner.
    always_comb begin
        host_gnt  = (state_q == HOST);
        core_gnt  = (state_q == CORE) ? owner_oh_q : '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt && host_req) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_gnt[i] && core_req[i]) begin
                mem_we    = core_we[i];
                mem_addr  = core_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read-return flags follow the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rvalid <= 1'b0;
            core_rvalid <= '0;
        end else begin
            host_rvalid <= host_gnt & host_req & ~host_we;
            core_rvalid <= core_gnt & core_req & ~core_we;
        end
    end

    assign rdata     = mem_rdata;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural memory, an
// expected-memory model and a read-data scoreboard queue.
module tb_shared_mem_arbiter;
    import shared_mem_pkg::*;

    localparam int NC = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              host_req, host_we, host_gnt, host_rvalid;
    logic [AW-1:0]     host_addr;
    logic [DW-1:0]     host_wdata;
    logic [NC-1:0]     core_req, core_we, core_gnt, core_rvalid;
    logic [NC*AW-1:0]  core_addr;
    logic [NC*DW-1:0]  core_wdata;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    arb_state_t        dbg_state;

    shared_mem_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .rdata(rdata), .host_rvalid(host_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Behavioural single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[9:0]];
    end

    logic [DW-1:0] model_mem [0:1023];
    logic [DW-1:0] exp_q[$];
    logic [NC:0]   rv_exp;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_wdata();
        for (int i = 0; i < NC; i++) core_wdata[i*DW +: DW] = DW'($urandom_range(0, 65535));
    endtask

    // One cycle: check grants, read returns and the memory port against the
    // expected owner, update the expected memory, then advance past the edge.
    task automatic cyc(input logic eh, input logic [NC-1:0] ec);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic acc, acc_we;
        @(negedge clk);
        chk("host_gnt", 32'(host_gnt), 32'(eh));
        chk("core_gnt", 32'(core_gnt), 32'(ec));
        chk("rvalid", 32'({host_rvalid, core_rvalid}), 32'(rv_exp));
        if (rv_exp != '0 && exp_q.size() > 0) begin
            d = exp_q.pop_front();
            chk("rdata", 32'(rdata), 32'(d));
        end
        acc = 1'b0; acc_we = 1'b0; a = '0; d = '0;
        if (eh && host_req) begin
            acc = 1'b1; acc_we = host_we; a = host_addr; d = host_wdata;
        end
        for (int i = 0; i < NC; i++) begin
            if (ec[i] && core_req[i]) begin
                acc = 1'b1; acc_we = core_we[i];
                a = core_addr[i*AW +: AW]; d = core_wdata[i*DW +: DW];
            end
        end
        chk("mem_we", 32'(mem_we), 32'(acc & acc_we));
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("mem_wdata", 32'(mem_wdata), 32'(d));
        if (acc && acc_we) model_mem[a[9:0]] = d;
        if (acc && !acc_we) exp_q.push_back(model_mem[a[9:0]]);
        rv_exp = {eh & host_req & ~host_we, ec & core_req & ~core_we};
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = '0;
            model_mem[i] = '0;
        end
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        rv_exp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_host_gnt", 32'(host_gnt), 32'd0);
        chk("rst_core_gnt", 32'(core_gnt), 32'd0);
        chk("rst_rvalid", 32'({host_rvalid, core_rvalid}), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 4'b0000);

        // Host and all cores request together: host wins, then 1024 writes
        host_req = 1; host_we = 1; core_req = 4'b1111;
        cyc(1'b0, 4'b0000);
        for (int i = 0; i < 1024; i++) begin
            host_addr  = AW'(i);
            host_wdata = DW'(i * 37 + 'h1234);
            core_req   = NC'($urandom_range(0, 15));
            core_we    = NC'($urandom_range(0, 15));
            core_addr  = (NC*AW)'({$urandom, $urandom});
            cyc(1'b1, 4'b0000);
        end
        host_addr = 16'h0040; host_wdata = 16'hBEEF; core_req = '0;
        cyc(1'b1, 4'b0000);
        // Host readback
        host_we = 0;
        host_addr = 16'h0040; cyc(1'b1, 4'b0000);
        host_addr = 16'd5;    cyc(1'b1, 4'b0000);
        host_addr = 16'd1023; cyc(1'b1, 4'b0000);
        host_addr = 16'h0040; cyc(1'b1, 4'b0000);
        host_req = 0; core_we = '0;
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0000);

        // Cores 0 and 2 alternate with an 8-cycle hold and one bubble
        for (int i = 0; i < NC; i++) core_addr[i*AW +: AW] = AW'(16'h0100 + i * 16);
        core_we = 4'b1111; core_req = 4'b0101;
        cyc(1'b0, 4'b0000);
        for (int k = 0; k < MH; k++) begin rand_wdata(); cyc(1'b0, 4'b0001); end
        cyc(1'b0, 4'b0000);
        for (int k = 0; k < MH; k++) begin rand_wdata(); cyc(1'b0, 4'b0100); end
        cyc(1'b0, 4'b0000);
        rand_wdata(); cyc(1'b0, 4'b0001);
        core_req = '0;
        cyc(1'b0, 4'b0001);
        cyc(1'b0, 4'b0000);

        // Lone requester core1 keeps the grant for 20 reads
        core_we = '0; core_req = 4'b0010;
        cyc(1'b0, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            core_addr[1*AW +: AW] = AW'($urandom_range(0, 1023));
            cyc(1'b0, 4'b0010);
        end
        core_req = '0;
        cyc(1'b0, 4'b0010);
        cyc(1'b0, 4'b0000);

        // Core3 reads 0x0040 holding 0xBEEF
        core_addr[3*AW +: AW] = 16'h0040; core_req = 4'b1000;
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b1000);
        core_req = '0;
        cyc(1'b0, 4'b1000);
        cyc(1'b0, 4'b0000);

        // Host preempts core2 mid-read; core2's read still returns
        core_addr[2*AW +: AW] = 16'd5; core_req = 4'b0100;
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0100);
        host_req = 1; host_we = 0; host_addr = 16'd1023;
        cyc(1'b0, 4'b0100);
        cyc(1'b0, 4'b0000);
        cyc(1'b1, 4'b0000);
        host_req = 0; core_req = '0;
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0000);

        // Asynchronous reset during a core0 write burst
        core_addr[0*AW +: AW] = 16'h0200; core_we = 4'b0001; core_req = 4'b0001;
        cyc(1'b0, 4'b0000);
        for (int k = 0; k < 3; k++) begin rand_wdata(); cyc(1'b0, 4'b0001); end
        core_wdata[0*DW +: DW] = ~model_mem[10'h200];
        #2 rst_n = 1'b0;
        #1;
        chk("arst_host_gnt", 32'(host_gnt), 32'd0);
        chk("arst_core_gnt", 32'(core_gnt), 32'd0);
        chk("arst_rvalid", 32'({host_rvalid, core_rvalid}), 32'd0);
        chk("arst_mem_we", 32'(mem_we), 32'd0);
        core_req = '0; core_we = '0; rv_exp = '0; exp_q.delete();
        @(posedge clk);
        #1;
        chk("arst_no_write", 32'(mem[10'h200]), 32'(model_mem[10'h200]));
        rst_n = 1'b1;
        cyc(1'b0, 4'b0000);

        // Pointer back at 0 after reset: core0 wins over core2
        core_req = 4'b0101;
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0001);
        core_req = '0;
        cyc(1'b0, 4'b0001);
        cyc(1'b0, 4'b0000);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
